// File: rtl/vga_sram_responder_if.sv
// CPU-side Wishbone port of the VGA/CPU SRAM responder.
// The bus master drives adr/dat/stb/we; the responder returns ack and read data.
interface vga_sram_responder_if #(
  parameter int ADR_WIDTH = 19,
  parameter int DAT_WIDTH = 8
);
  logic [ADR_WIDTH-1:0] I_wb_adr;
  logic [DAT_WIDTH-1:0] I_wb_dat;
  logic                 I_wb_stb;
  logic                 I_wb_we;
  logic                 O_wb_ack;
  logic [DAT_WIDTH-1:0] O_wb_dat;

  modport master (
    output I_wb_adr, I_wb_dat, I_wb_stb, I_wb_we,
    input  O_wb_ack, O_wb_dat
  );

  modport slave (
    input  I_wb_adr, I_wb_dat, I_wb_stb, I_wb_we,
    output O_wb_ack, O_wb_dat
  );
endinterface

// File: rtl/vga_sram_responder.sv
// Shares one asynchronous SRAM between fixed-latency VGA reads and an 8-bit Wishbone CPU port.
// Optional macro SRAM_WRITE_GAP_EN inserts one turnaround slot after every CPU write.
//
// slot      | meaning
// ----------+--------------------------------------------------------------
// IDLE      | all strobes high, SRAM data pins released
// VGA_RD    | VGA read; data captured into O_vga_dat when the slot ends
// CPU_RD    | CPU read; data captured into O_wb_dat and ack raised
// CPU_WR    | CPU write; SRAM data pins driven, ack raised when the slot ends
// GAP       | (SRAM_WRITE_GAP_EN only) bus turnaround after CPU_WR
module vga_sram_responder #(
  parameter int ADR_WIDTH = 19,
  parameter int DAT_WIDTH = 8
) (
  input  logic                 I_clk,
  input  logic                 I_reset_n,
  input  logic                 I_vga_req,
  input  logic [ADR_WIDTH-1:0] I_vga_adr,
  output logic [DAT_WIDTH-1:0] O_vga_dat,
  vga_sram_responder_if.slave  wb,
  output logic [ADR_WIDTH-1:0] O_sram_adr,
  output logic [DAT_WIDTH-1:0] O_sram_dat,
  output logic                 O_sram_dat_oe,
  input  logic [DAT_WIDTH-1:0] I_sram_dat,
  output logic                 O_sram_ce_n,
  output logic                 O_sram_oe_n,
  output logic                 O_sram_we_n
);

`ifdef SRAM_WRITE_GAP_EN
  typedef enum logic [2:0] {
    SLOT_IDLE   = 3'd0,
    SLOT_VGA_RD = 3'd1,
    SLOT_CPU_RD = 3'd2,
    SLOT_CPU_WR = 3'd3,
    SLOT_GAP    = 3'd4
  } slot_t;
`else
  typedef enum logic [2:0] {
    SLOT_IDLE   = 3'd0,
    SLOT_VGA_RD = 3'd1,
    SLOT_CPU_RD = 3'd2,
    SLOT_CPU_WR = 3'd3
  } slot_t;
`endif

  slot_t                slot_q;
  slot_t                slot_d;
  logic [ADR_WIDTH-1:0] adr_d;
  logic [DAT_WIDTH-1:0] dat_d;
  logic                 ce_n_d;
  logic                 oe_n_d;
  logic                 we_n_d;
  logic                 dat_oe_d;
  logic                 cpu_busy;

`ifdef SRAM_WRITE_GAP_EN
  logic                 vga_pend_q;
  logic                 vga_pend_d;
  logic [ADR_WIDTH-1:0] vga_pend_adr_q;
  logic [ADR_WIDTH-1:0] vga_pend_adr_d;
`endif

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      slot_q        <= SLOT_IDLE;
      O_sram_adr    <= '0;
      O_sram_dat    <= '0;
      O_sram_ce_n   <= 1'b1;
      O_sram_oe_n   <= 1'b1;
      O_sram_we_n   <= 1'b1;
      O_sram_dat_oe <= 1'b0;
`ifdef SRAM_WRITE_GAP_EN
      vga_pend_q     <= 1'b0;
      vga_pend_adr_q <= '0;
`endif
    end else begin
      slot_q        <= slot_d;
      O_sram_adr    <= adr_d;
      O_sram_dat    <= dat_d;
      O_sram_ce_n   <= ce_n_d;
      O_sram_oe_n   <= oe_n_d;
      O_sram_we_n   <= we_n_d;
      O_sram_dat_oe <= dat_oe_d;
`ifdef SRAM_WRITE_GAP_EN
      vga_pend_q     <= vga_pend_d;
      vga_pend_adr_q <= vga_pend_adr_d;
`endif
    end
  end

  always_comb begin
    slot_d   = SLOT_IDLE;
    adr_d    = O_sram_adr;
    dat_d    = O_sram_dat;
    ce_n_d   = 1'b1;
    oe_n_d   = 1'b1;
    we_n_d   = 1'b1;
    dat_oe_d = 1'b0;
    // ack blocks a new grant so a strobe held across the ack is not served twice
    cpu_busy = (slot_q == SLOT_CPU_RD) || (slot_q == SLOT_CPU_WR) || wb.O_wb_ack;
`ifdef SRAM_WRITE_GAP_EN
    vga_pend_d     = vga_pend_q;
    vga_pend_adr_d = vga_pend_adr_q;
    if (slot_q == SLOT_CPU_WR) begin
      slot_d = SLOT_GAP;
      if (I_vga_req) begin
        vga_pend_d     = 1'b1;
        vga_pend_adr_d = I_vga_adr;
      end
    end else if (vga_pend_q) begin
      slot_d     = SLOT_VGA_RD;
      adr_d      = vga_pend_adr_q;
      vga_pend_d = 1'b0;
    end else
`endif
    if (I_vga_req) begin
      slot_d = SLOT_VGA_RD;
      adr_d  = I_vga_adr;
    end else if (wb.I_wb_stb && !cpu_busy) begin
      adr_d = wb.I_wb_adr;
      if (wb.I_wb_we) begin
        slot_d = SLOT_CPU_WR;
        dat_d  = wb.I_wb_dat;
      end else begin
        slot_d = SLOT_CPU_RD;
      end
    end

    case (slot_d)
      SLOT_VGA_RD, SLOT_CPU_RD: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
      end
      SLOT_CPU_WR: begin
        ce_n_d   = 1'b0;
        we_n_d   = 1'b0;
        dat_oe_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      O_vga_dat    <= '0;
      wb.O_wb_dat  <= '0;
      wb.O_wb_ack  <= 1'b0;
    end else begin
      wb.O_wb_ack <= (slot_q == SLOT_CPU_RD) || (slot_q == SLOT_CPU_WR);
      if (slot_q == SLOT_VGA_RD) O_vga_dat <= I_sram_dat;
      if (slot_q == SLOT_CPU_RD) wb.O_wb_dat <= I_sram_dat;
    end
  end

endmodule

// File: doc/vga_sram_responder.md
Name: vga_sram_responder

Overview:
- SRAM-side responder for the VGA scanout fetch interface (req/adr/dat) plus an 8-bit Wishbone CPU port, both served from one external 512K x 8 asynchronous SRAM.
- Fixed-latency VGA reads with strict priority; CPU accesses fill free slots between VGA requests.
- Sits between the VGA controller, the CPU bus and the SRAM pins, all in the VGA pixel-clock domain.

Parameters:
- ADR_WIDTH, 19, SRAM/VGA/CPU address width
- DAT_WIDTH, 8, data width

Ports:
- I_clk  in  1  single clock (pixel clock)
- I_reset_n  in  1  asynchronous, active-low reset
- I_vga_req  in  1  single-cycle VGA read strobe
- I_vga_adr  in  ADR_WIDTH  VGA read address, valid with I_vga_req
- O_vga_dat  out  DAT_WIDTH  VGA read data, held until next VGA read
- I_wb_adr  in  ADR_WIDTH  CPU address
- I_wb_dat  in  DAT_WIDTH  CPU write data
- I_wb_stb  in  1  CPU strobe, held until ack
- I_wb_we  in  1  CPU write enable
- O_wb_ack  out  1  single-cycle CPU ack
- O_wb_dat  out  DAT_WIDTH  CPU read data
- O_sram_adr  out  ADR_WIDTH  SRAM address
- O_sram_dat  out  DAT_WIDTH  SRAM write data
- O_sram_dat_oe  out  1  tristate enable for SRAM data pins
- I_sram_dat  in  DAT_WIDTH  SRAM read data
- O_sram_ce_n, O_sram_oe_n, O_sram_we_n  out  1 each  SRAM strobes, active low

Behaviour:
- Reset (async assert, sync release): ce_n/oe_n/we_n=1, dat_oe=0, sram_adr=0, sram_dat=0, vga_dat=0, wb_dat=0, wb_ack=0, slot=IDLE, no CPU access pending. Reset during an access aborts it; no ack is issued.
- SRAM time is divided into one-cycle slots. The slot for cycle N+1 is chosen at the edge ending cycle N and registered onto the SRAM pins.
- Slot states: IDLE, VGA_RD, CPU_RD, CPU_WR, plus GAP with the optional feature.
- Arbitration at each edge:
  - I_vga_req=1 -> VGA_RD with O_sram_adr=I_vga_adr. This always wins, including over a CPU strobe in the same cycle.
  - Otherwise, I_wb_stb=1 and no CPU access in flight or acking -> CPU_RD or CPU_WR, selected by I_wb_we.
  - Otherwise -> IDLE.
- VGA_RD: ce_n=0, oe_n=0, we_n=1, dat_oe=0. At the slot-ending edge, O_vga_dat<=I_sram_dat.
  - Latency: req in cycle N -> data on O_vga_dat from cycle N+2.
  - Back-to-back VGA reqs are supported at one per cycle.
- CPU_RD: same pins as VGA_RD. At the slot-ending edge, O_wb_dat<=I_sram_dat and O_wb_ack<=1 for one cycle. O_vga_dat is unchanged.
- CPU_WR: ce_n=0, oe_n=1, we_n=0, dat_oe=1, O_sram_dat=I_wb_dat. Ack is issued the same way as for CPU_RD.
- CPU latency: stb sampled in cycle N with the slot granted -> ack in cycle N+2. Each cycle of VGA contention adds one cycle.
- CPU access rules:
  - A new CPU access is not started while one is in flight or while O_wb_ack=1, so a stb held across the ack is not served twice.
  - A CPU request deferred by a VGA read keeps its address and data sampled live from the bus; the master holds them stable until ack.
- IDLE: all strobes high, dat_oe=0; O_sram_adr keeps its last value.
- Addresses pass through unmodified; there is no wrap or offset logic.

Optional Feature:
- Macro: SRAM_WRITE_GAP_EN.
- With it: every CPU_WR slot is followed by exactly one GAP slot (strobes high, dat_oe=0) for bus turnaround.
  - A VGA req arriving during CPU_WR is deferred to after the GAP, so its data appears at N+3.
  - VGA reqs must therefore be spaced at least 2 cycles apart, which the scanout guarantees.
- Without it: no GAP state exists and a write may be followed directly by any slot.

Test Plan:
- Reset: hold I_reset_n=0 mid-access -> all strobes 1, dat_oe=0, O_wb_ack=0 immediately; no ack after release.
- VGA read: SRAM model mem[0x20000]=0xA5, I_vga_req=1 with adr 0x20000 in cycle N -> oe_n=0 and adr=0x20000 in N+1; O_vga_dat=0xA5 from N+2.
- CPU write/read: stb+we, adr 0x40010, dat 0x3C -> we_n=0 for exactly one cycle, ack at N+2. Then a read of the same address -> O_wb_dat=0x3C with ack at N+2.
- Collision: I_vga_req and I_wb_stb asserted in the same cycle -> VGA_RD first, CPU slot next, ack at N+3; O_vga_dat is not disturbed by CPU data.
- Held stb: keep stb=1 for 2 cycles after ack -> exactly one SRAM access per ack, never a duplicate write.
- SRAM_WRITE_GAP_EN: CPU_WR in cycle N+1 and VGA req in N+1 -> GAP in N+2, VGA_RD in N+3, vga data in N+4; with the macro off, VGA_RD is in N+2.
